scoreboard_counted: RTL



---
 rtl/scoreboard_counted_pkg.sv | 22 ++
 rtl/scoreboard_counted_entry.sv | 67 ++++++
 rtl/scoreboard_counted.sv | 102 ++++++++++
 3 files changed

// File: rtl/scoreboard_counted_pkg.sv
// Shared defaults and width helpers for the decode-stage register/predicate scoreboard.
package scoreboard_counted_pkg;

    localparam int unsigned SB_NUM_LANES = 4;
    localparam int unsigned SB_NUM_REGS  = 32;
    localparam int unsigned SB_NUM_PREDS = 3;
    localparam int unsigned SB_CNT_W     = 2;

    // Signed width able to hold cnt + inc - dec without wrapping.
    function automatic int unsigned sb_arith_w(input int unsigned cnt_w, input int unsigned lanes);
        return cnt_w + $clog2(lanes + 1) + 1;
    endfunction

    function automatic int unsigned sb_cnt_max(input int unsigned cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    function automatic int unsigned sb_lane_lo(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/scoreboard_counted_entry.sv
// One saturating in-flight write counter: nets per-lane issue hits against writeback hits each cycle.
module sb_entry_counter
    import scoreboard_counted_pkg::*;
#(
    parameter int unsigned CNT_W     = SB_CNT_W,
    parameter int unsigned NUM_LANES = SB_NUM_LANES
)(
    input  logic                 clkrst_core_clk,
    input  logic                 clkrst_core_rst,
    input  logic [NUM_LANES-1:0] i_inc_hit,
    input  logic [NUM_LANES-1:0] i_dec_hit,
    input  logic                 i_squash,
    output logic                 o_busy,
    output logic                 o_sat,
    output logic                 o_ovf,
    output logic                 o_unf
);

    localparam int unsigned ARITH_W = sb_arith_w(CNT_W, NUM_LANES);
    localparam logic signed [ARITH_W-1:0] MAX_S = ARITH_W'(sb_cnt_max(CNT_W));

    logic        [CNT_W-1:0]   r_cnt;
    logic        [CNT_W-1:0]   w_cnt_d;
    logic signed [ARITH_W-1:0] w_inc;
    logic signed [ARITH_W-1:0] w_dec;
    logic signed [ARITH_W-1:0] w_cnt_ext;
    logic signed [ARITH_W-1:0] w_next;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            w_inc = w_inc + ARITH_W'(i_inc_hit[l]);
            w_dec = w_dec + ARITH_W'(i_dec_hit[l]);
        end
        w_cnt_ext = ARITH_W'(r_cnt);
        w_next    = w_cnt_ext + w_inc - w_dec;
    end

    // Squash keeps only this cycle's writeback hits, which that same writeback retires, so it nets to zero.
    always_comb begin
        o_ovf   = 1'b0;
        o_unf   = 1'b0;
        w_cnt_d = w_next[CNT_W-1:0];
        if (i_squash) begin
            w_cnt_d = '0;
        end else if (w_next > MAX_S) begin
            o_ovf   = 1'b1;
            w_cnt_d = '1;
        end else if (w_next[ARITH_W-1]) begin
            o_unf   = 1'b1;
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_sat  = (r_cnt == '1);

endmodule

// File: rtl/scoreboard_counted.sv
// Decode-stage scoreboard: per-GPR and per-predicate in-flight write counters with busy/sat bitmaps.
module scoreboard_counted
    import scoreboard_counted_pkg::*;
#(
    parameter int unsigned NUM_LANES = SB_NUM_LANES,
    parameter int unsigned NUM_REGS  = SB_NUM_REGS,
    parameter int unsigned NUM_PREDS = SB_NUM_PREDS,
    parameter int unsigned CNT_W     = SB_CNT_W,
    parameter bit          R0_ZERO   = 1'b1,
    localparam int unsigned REG_W    = $clog2(NUM_REGS)
)(
    input  logic                         clkrst_core_clk,
    input  logic                         clkrst_core_rst,
    input  logic [NUM_LANES*REG_W-1:0]   d2pc_out_rd_num,
    input  logic [NUM_LANES-1:0]         d2pc_out_rd_we,
    input  logic [NUM_LANES-1:0]         d2pc_out_pred_we,
    input  logic [NUM_LANES*REG_W-1:0]   wb2rf_rd_num,
    input  logic [NUM_LANES-1:0]         wb2rf_rd_we,
    input  logic [NUM_LANES-1:0]         wb2rf_pred_we,
    input  logic                         sq_valid,
    output logic [NUM_REGS-1:0]          sb2d_reg_scoreboard,
    output logic [NUM_PREDS-1:0]         sb2d_pred_scoreboard,
    output logic [NUM_REGS-1:0]          sb2d_reg_sat,
    output logic [NUM_PREDS-1:0]         sb2d_pred_sat,
    output logic                         sb_err
);

    logic [NUM_REGS-1:0]  w_reg_ovf;
    logic [NUM_REGS-1:0]  w_reg_unf;
    logic [NUM_PREDS-1:0] w_pred_ovf;
    logic [NUM_PREDS-1:0] w_pred_unf;
    logic                 r_sb_err;

    for (genvar e = 0; e < NUM_REGS; e++) begin : g_reg
        logic [NUM_LANES-1:0] w_inc_hit;
        logic [NUM_LANES-1:0] w_dec_hit;

        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            localparam int unsigned LO = sb_lane_lo(l, REG_W);
            // GPR 0 is hardwired when R0_ZERO, so its counter never sees an event.
            if (R0_ZERO && e == 0) begin : g_r0
                assign w_inc_hit[l] = 1'b0;
                assign w_dec_hit[l] = 1'b0;
            end else begin : g_dec
                assign w_inc_hit[l] = d2pc_out_rd_we[l] && (d2pc_out_rd_num[LO +: REG_W] == REG_W'(e));
                assign w_dec_hit[l] = wb2rf_rd_we[l]    && (wb2rf_rd_num[LO +: REG_W]    == REG_W'(e));
            end
        end

        sb_entry_counter #(
            .CNT_W     (CNT_W),
            .NUM_LANES (NUM_LANES)
        ) u_cnt (
            .clkrst_core_clk (clkrst_core_clk),
            .clkrst_core_rst (clkrst_core_rst),
            .i_inc_hit       (w_inc_hit),
            .i_dec_hit       (w_dec_hit),
            .i_squash        (sq_valid),
            .o_busy          (sb2d_reg_scoreboard[e]),
            .o_sat           (sb2d_reg_sat[e]),
            .o_ovf           (w_reg_ovf[e]),
            .o_unf           (w_reg_unf[e])
        );
    end

    for (genvar p = 0; p < NUM_PREDS; p++) begin : g_pred
        logic [NUM_LANES-1:0] w_inc_hit;
        logic [NUM_LANES-1:0] w_dec_hit;

        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            localparam int unsigned LO = sb_lane_lo(l, REG_W);
            assign w_inc_hit[l] = d2pc_out_pred_we[l] && (d2pc_out_rd_num[LO +: REG_W] == REG_W'(p));
            assign w_dec_hit[l] = wb2rf_pred_we[l]    && (wb2rf_rd_num[LO +: REG_W]    == REG_W'(p));
        end

        sb_entry_counter #(
            .CNT_W     (CNT_W),
            .NUM_LANES (NUM_LANES)
        ) u_cnt (
            .clkrst_core_clk (clkrst_core_clk),
            .clkrst_core_rst (clkrst_core_rst),
            .i_inc_hit       (w_inc_hit),
            .i_dec_hit       (w_dec_hit),
            .i_squash        (sq_valid),
            .o_busy          (sb2d_pred_scoreboard[p]),
            .o_sat           (sb2d_pred_sat[p]),
            .o_ovf           (w_pred_ovf[p]),
            .o_unf           (w_pred_unf[p])
        );
    end

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            r_sb_err <= 1'b0;
        end else begin
            r_sb_err <= r_sb_err | (|w_reg_ovf) | (|w_reg_unf) | (|w_pred_ovf) | (|w_pred_unf);
        end
    end

    assign sb_err = r_sb_err;

endmodule
